// File: rtl/multicycle_ctrl_fsm_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_fsm_if
//   Shared memory-port handshake between the multi-cycle sequencer and the
//   memory. One port carries both instruction fetch and data access.
//
//   Signals:
//     mem_req    sequencer -> memory  request active (fetch or data)
//     mem_we     sequencer -> memory  write enable qualifying mem_req
//     mem_ready  memory -> sequencer  request completes this cycle
//     opcode     memory -> sequencer  instr[6:0] of the read data
//
//   Modports:
//     master  sequencer side
//     slave   memory side
// -----------------------------------------------------------------------------
interface multicycle_ctrl_fsm_if;
    logic       mem_req;
    logic       mem_we;
    logic       mem_ready;
    logic [6:0] opcode;

    modport master (output mem_req, output mem_we, input mem_ready, input opcode);
    modport slave  (input mem_req, input mem_we, output mem_ready, output opcode);
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_fsm
//   Multi-cycle control sequencer for a RISC-V datapath. Steps each instruction
//   through FETCH/DECODE/EXEC/MEM/WB, shares one memory port between fetch and
//   data access with a bounded wait, and traps on an illegal opcode or a memory
//   timeout. The trap is sticky; only reset_n leaves it.
//
//   Parameters:
//     TIMEOUT_CYCLES  max consecutive request cycles without mem_ready (>=1)
//     CNT_W           width of the retired-instruction counter
//
//   Ports:
//     clk             clock, rising edge
//     reset_n         synchronous reset, active-low
//     mem             memory handshake (master modport)
//     ir_write_o      load IR from memory data (FETCH, on mem_ready)
//     pc_write_o      PC <= PC+4 (FETCH, on mem_ready)
//     branch_o        datapath may take branch target if ALU zero
//     alu_src_o       0 = rs2, 1 = immediate
//     alu_op_o        R=111, I-ALU=000, address add=010, branch compare=001
//     reg_write_o     register-file write
//     mem_to_reg_o    writeback source: 1 = memory, 0 = ALU
//     instr_retire_o  one-cycle pulse on the last cycle of each instruction
//     trap_o          sticky halt indicator
//     trap_cause_o    01 illegal opcode, 10 bus timeout, 00 none
//     state_o         current state code, for debug
//     retire_count_o  retired-instruction count (only with CTRL_RETIRE_CNT_EN)
//
//   Build option:
//     CTRL_RETIRE_CNT_EN  adds retire_count_o; counter frozen while trapped.
// -----------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    multicycle_ctrl_fsm_if.master   mem,
    output logic                    ir_write_o,
    output logic                    pc_write_o,
    output logic                    branch_o,
    output logic                    alu_src_o,
    output logic [2:0]              alu_op_o,
    output logic                    reg_write_o,
    output logic                    mem_to_reg_o,
    output logic                    instr_retire_o,
    output logic                    trap_o,
    output logic [1:0]              trap_cause_o,
    output logic [2:0]              state_o
`ifdef CTRL_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0]        retire_count_o
`endif
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam int unsigned WAIT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd7
    } state_e;

    // Controls that depend only on state and the latched opcode.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       branch;
        logic       alu_src;
        logic [2:0] alu_op;
        logic       reg_write;
        logic       mem_to_reg;
        logic       retire;
        logic       trap;
    } ctrl_t;

    function automatic logic is_legal(input logic [6:0] opc);
        return (opc == OP_R) || (opc == OP_I) || (opc == OP_LOAD) ||
               (opc == OP_STORE) || (opc == OP_BRANCH);
    endfunction

    function automatic ctrl_t decode(input state_e s, input logic [6:0] opc);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: c.mem_req = 1'b1;
            EXEC: begin
                case (opc)
                    OP_R:      c.alu_op = 3'b111;
                    OP_I:      begin c.alu_op = 3'b000; c.alu_src = 1'b1; end
                    OP_LOAD,
                    OP_STORE:  begin c.alu_op = 3'b010; c.alu_src = 1'b1; end
                    OP_BRANCH: begin c.alu_op = 3'b001; c.branch = 1'b1; c.retire = 1'b1; end
                    default:   ;
                endcase
            end
            // Address add held through the whole access so the address stays stable.
            MEM: begin
                c.mem_req = 1'b1;
                c.mem_we  = (opc == OP_STORE);
                c.alu_op  = 3'b010;
                c.alu_src = 1'b1;
            end
            WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = (opc == OP_LOAD);
                c.retire     = 1'b1;
            end
            TRAP:    c.trap = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    state_e              state_q, state_d;
    logic [6:0]          opcode_q, opcode_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [1:0]          cause_q, cause_d;
    ctrl_t               ctrl_q;

    // NOTE: every variable gets a default first so no path leaves it unassigned
    // (an unassigned path would infer a latch).
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        wait_d   = wait_q;
        cause_d  = cause_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH, MEM: begin
                if (mem.mem_ready) begin
                    if (state_q == FETCH) begin
                        opcode_d = mem.opcode;
                        state_d  = DECODE;
                    end else begin
                        state_d = (opcode_q == OP_LOAD) ? WB : FETCH;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = TRAP;
                    cause_d = 2'b10;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DECODE: begin
                if (is_legal(opcode_q)) begin
                    state_d = EXEC;
                end else begin
                    state_d = TRAP;
                    cause_d = 2'b01;
                end
            end
            EXEC: begin
                if (opcode_q == OP_BRANCH) begin
                    state_d = FETCH;
                end else if (opcode_q == OP_LOAD || opcode_q == OP_STORE) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            WB:      state_d = FETCH;
            TRAP:    state_d = TRAP;
            default: state_d = IDLE;
        endcase
        // Any state change restarts the wait count, which covers every entry
        // into FETCH or MEM.
        if (state_d != state_q) begin
            wait_d = '0;
        end
    end

`ifdef CTRL_RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_cnt_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            opcode_q <= '0;
            wait_q   <= '0;
            cause_q  <= '0;
            ctrl_q   <= '0;
`ifdef CTRL_RETIRE_CNT_EN
            retire_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            wait_q   <= wait_d;
            cause_q  <= cause_d;
            // Registered from the next state, so outputs line up with state_q.
            ctrl_q   <= decode(state_d, opcode_d);
`ifdef CTRL_RETIRE_CNT_EN
            if (instr_retire_o) begin
                retire_cnt_q <= retire_cnt_q + CNT_W'(1);
            end
`endif
        end
    end

    // Completion-qualified controls must react to mem_ready in the same cycle.
    assign ir_write_o     = (state_q == FETCH) && mem.mem_ready;
    assign pc_write_o     = (state_q == FETCH) && mem.mem_ready;
    assign instr_retire_o = ctrl_q.retire ||
                            ((state_q == MEM) && (opcode_q == OP_STORE) && mem.mem_ready);

    assign mem.mem_req    = ctrl_q.mem_req;
    assign mem.mem_we     = ctrl_q.mem_we;
    assign branch_o       = ctrl_q.branch;
    assign alu_src_o      = ctrl_q.alu_src;
    assign alu_op_o       = ctrl_q.alu_op;
    assign reg_write_o    = ctrl_q.reg_write;
    assign mem_to_reg_o   = ctrl_q.mem_to_reg;
    assign trap_o         = ctrl_q.trap;
    assign trap_cause_o   = cause_q;
    assign state_o        = state_q;
`ifdef CTRL_RETIRE_CNT_EN
    assign retire_count_o = retire_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
//   Directed bench for multicycle_ctrl_fsm (TIMEOUT_CYCLES = 4). Instruction
//   descriptors (opcode, fetch waits, data waits) are expanded into a per-cycle
//   table of bus inputs and expected outputs; a compare process checks the DUT
//   against that table every cycle. Literal pins check both model and DUT.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;

    localparam int TO    = 4;
    localparam int CNT_W = 32;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_L    = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_BAD  = 7'b1111111;
    localparam logic [6:0] OP_JUNK = 7'b1010101;

    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3,
                   S_MEM = 4, S_WB = 5, S_TRAP = 7;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if bus();

    logic       ir_write_o, pc_write_o, branch_o, alu_src_o;
    logic [2:0] alu_op_o;
    logic       reg_write_o, mem_to_reg_o, instr_retire_o, trap_o;
    logic [1:0] trap_cause_o;
    logic [2:0] state_o;
`ifdef CTRL_RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_count_o;
`endif

    multicycle_ctrl_fsm #(.TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mem            (bus.master),
        .ir_write_o     (ir_write_o),
        .pc_write_o     (pc_write_o),
        .branch_o       (branch_o),
        .alu_src_o      (alu_src_o),
        .alu_op_o       (alu_op_o),
        .reg_write_o    (reg_write_o),
        .mem_to_reg_o   (mem_to_reg_o),
        .instr_retire_o (instr_retire_o),
        .trap_o         (trap_o),
        .trap_cause_o   (trap_cause_o),
        .state_o        (state_o)
`ifdef CTRL_RETIRE_CNT_EN
        ,
        .retire_count_o (retire_count_o)
`endif
    );

    typedef struct {
        bit         rst_n;
        bit         rdy;
        logic [6:0] opc;
        bit         care;
        logic [2:0] st;
        bit         req, we, irw, pcw, br, asrc;
        logic [2:0] aop;
        bit         rw, m2r, ret, trap;
        logic [1:0] cause;
        int         cnt;
    } vec_t;

    vec_t       q[$];
    vec_t       cur;
    bit         cmp_on = 1'b0;
    int         n_cmp  = 0;
    int         n_fail = 0;
    int         cnt_m  = 0;
    logic [6:0] lat    = OP_JUNK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Expected outputs for one cycle, straight from the output table of each state.
    task automatic emit(input int st, input bit rdy, input logic [6:0] bopc,
                        input bit rst_n, input logic [1:0] cause);
        vec_t v;
        v = '{default: 0};
        v.rst_n = rst_n; v.rdy = rdy; v.opc = bopc; v.care = 1'b1;
        v.st = 3'(st); v.cnt = cnt_m;
        case (st)
            S_FETCH: begin v.req = 1; v.irw = rdy; v.pcw = rdy; end
            S_EXEC: begin
                if (lat == OP_R)                      v.aop = 3'b111;
                else if (lat == OP_I)                 begin v.aop = 3'b000; v.asrc = 1; end
                else if (lat == OP_L || lat == OP_S)  begin v.aop = 3'b010; v.asrc = 1; end
                else if (lat == OP_B)                 begin v.aop = 3'b001; v.br = 1; v.ret = 1; end
            end
            S_MEM: begin
                v.req = 1; v.we = (lat == OP_S); v.aop = 3'b010; v.asrc = 1;
                v.ret = (lat == OP_S) && rdy;
            end
            S_WB:   begin v.rw = 1; v.m2r = (lat == OP_L); v.ret = 1; end
            S_TRAP: begin v.trap = 1; v.cause = cause; end
            default: ;
        endcase
        q.push_back(v);
        if (v.ret) cnt_m++;
        if (!rst_n) cnt_m = 0;
    endtask

    task automatic do_reset();
        vec_t v;
        v = '{default: 0};
        v.rst_n = 0; v.care = 0; v.opc = OP_JUNK;
        q.push_back(v);
        cnt_m = 0;
        lat = OP_JUNK;
        emit(S_IDLE, 1, OP_JUNK, 1, 2'b00);
    endtask

    // Request phase: nwait cycles without ready, then ready; gives up after TO.
    task automatic req_phase(input int st, input int nwait, input logic [6:0] bopc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < TO; i++) begin
            if (i == nwait) begin
                emit(st, 1, bopc, 1, 2'b00);
                ok = 1'b1;
                return;
            end
            emit(st, 0, bopc, 1, 2'b00);
        end
    endtask

    task automatic trap_for(input logic [1:0] cause, input int n);
        repeat (n) emit(S_TRAP, 1, OP_JUNK, 1, cause);
    endtask

    task automatic instr(input logic [6:0] opc, input int fw, input int mw, input int ntrap);
        bit ok;
        req_phase(S_FETCH, fw, opc, ok);
        if (!ok) begin trap_for(2'b10, ntrap); return; end
        lat = opc;
        emit(S_DECODE, 1, OP_JUNK, 1, 2'b00);
        if (!(opc == OP_R || opc == OP_I || opc == OP_L || opc == OP_S || opc == OP_B)) begin
            trap_for(2'b01, ntrap);
            return;
        end
        emit(S_EXEC, 1, OP_JUNK, 1, 2'b00);
        if (opc == OP_B) return;
        if (opc == OP_L || opc == OP_S) begin
            req_phase(S_MEM, mw, OP_JUNK, ok);
            if (!ok) begin trap_for(2'b10, ntrap); return; end
            if (opc == OP_S) return;
        end
        emit(S_WB, 1, OP_JUNK, 1, 2'b00);
    endtask

    task automatic play();
        while (q.size() > 0) begin
            @(posedge clk);
            #1;
            cur = q.pop_front();
            reset_n       = cur.rst_n;
            bus.mem_ready = cur.rdy;
            bus.opcode    = cur.opc;
            cmp_on        = cur.care;
        end
        @(posedge clk);
        #1;
        cmp_on = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            check("state",        32'(state_o),        32'(cur.st));
            check("mem_req",      32'(bus.mem_req),    32'(cur.req));
            check("mem_we",       32'(bus.mem_we),     32'(cur.we));
            check("ir_write",     32'(ir_write_o),     32'(cur.irw));
            check("pc_write",     32'(pc_write_o),     32'(cur.pcw));
            check("branch",       32'(branch_o),       32'(cur.br));
            check("alu_src",      32'(alu_src_o),      32'(cur.asrc));
            check("alu_op",       32'(alu_op_o),       32'(cur.aop));
            check("reg_write",    32'(reg_write_o),    32'(cur.rw));
            check("mem_to_reg",   32'(mem_to_reg_o),   32'(cur.m2r));
            check("instr_retire", 32'(instr_retire_o), 32'(cur.ret));
            check("trap",         32'(trap_o),         32'(cur.trap));
            check("trap_cause",   32'(trap_cause_o),   32'(cur.cause));
`ifdef CTRL_RETIRE_CNT_EN
            check("retire_count", 32'(retire_count_o), 32'(cur.cnt));
`endif
        end
    end

    initial begin
        int n0;
        bit ok;
        bus.mem_ready = 1'b0;
        bus.opcode    = OP_JUNK;

        // Segment A: every opcode class, wait states, fetch ready on last allowed cycle, illegal trap.
        do_reset();
        n0 = q.size(); instr(OP_R, 0, 0, 0); check("model_len_r", 32'(q.size() - n0), 32'd4);
        n0 = q.size(); instr(OP_B, 0, 0, 0); check("model_len_branch", 32'(q.size() - n0), 32'd3);
        n0 = q.size(); instr(OP_L, 0, 3, 0); check("model_len_load_3ws", 32'(q.size() - n0), 32'd8);
        instr(OP_S, 0, 1, 0);
        instr(OP_I, 2, 0, 0);
        instr(OP_R, 3, 0, 0);
        instr(OP_BAD, 0, 0, 20);
        play();
        check("pin_illegal_trap",  32'(trap_o),       32'd1);
        check("pin_illegal_cause", 32'(trap_cause_o), 32'd1);
        check("pin_illegal_state", 32'(state_o),      32'd7);
        check("pin_illegal_req",   32'(bus.mem_req),  32'd0);
`ifdef CTRL_RETIRE_CNT_EN
        check("pin_retire_6", 32'(retire_count_o), 32'd6);
`endif

        // Segment B: fetch never completes -> timeout trap after exactly TO request cycles.
        do_reset();
        n0 = q.size(); instr(OP_R, 99, 0, 5);
        check("model_len_timeout", 32'(q.size() - n0), 32'(TO + 5));
        play();
        check("pin_timeout_trap",  32'(trap_o),       32'd1);
        check("pin_timeout_cause", 32'(trap_cause_o), 32'd2);

        // Segment C: reset during the MEM phase of a store, then R-type and branch.
        do_reset();
        req_phase(S_FETCH, 0, OP_S, ok);
        lat = OP_S;
        emit(S_DECODE, 1, OP_JUNK, 1, 2'b00);
        emit(S_EXEC,   1, OP_JUNK, 1, 2'b00);
        emit(S_MEM,    0, OP_JUNK, 1, 2'b00);
        emit(S_MEM,    0, OP_JUNK, 0, 2'b00);
        emit(S_IDLE,   1, OP_JUNK, 1, 2'b00);
        instr(OP_R, 0, 0, 0);
        instr(OP_B, 1, 0, 0);
        instr(OP_BAD, 0, 0, 3);
        play();
        check("pin_c_state", 32'(state_o), 32'd7);
`ifdef CTRL_RETIRE_CNT_EN
        check("pin_retire_2", 32'(retire_count_o), 32'd2);
`endif

        // Reset leaves the trap.
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("pin_rst_state", 32'(state_o),      32'd0);
        check("pin_rst_trap",  32'(trap_o),       32'd0);
        check("pin_rst_cause", 32'(trap_cause_o), 32'd0);
        check("pin_rst_req",   32'(bus.mem_req),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
